stream_mux_rr: RTL and testbench

//  Parametrised N-channel, DW-bit registered multiplexer. It is the pipelined successor to the 8:1

---
 rtl/stream_mux_rr_if.sv | 29 ++
 rtl/stream_mux_rr.sv | 95 +++++++++
 tb/tb_stream_mux_rr.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/stream_mux_rr_if.sv
// Stream mux bus: N_CH valid/ready input channels plus one registered output stream.
interface stream_mux_rr_if #(
  parameter int unsigned N_CH = 8,
  parameter int unsigned DW   = 1
);
  localparam int unsigned SEL_W = $clog2(N_CH);

  logic                 mode;
  logic [SEL_W-1:0]     sel;
  logic [N_CH*DW-1:0]   in_data;
  logic [N_CH-1:0]      in_valid;
  logic [N_CH-1:0]      in_ready;
  logic [DW-1:0]        out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SEL_W-1:0]     out_ch;

  // Driver side: sources, select control and the sink's ready.
  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  // Mux side.
  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux: fixed select (mode 0) or round-robin (mode 1).
module stream_mux_rr #(
  parameter int unsigned N_CH = 8,
  parameter int unsigned DW   = 1
) (
  input  logic          clk,
  input  logic          rst,
  stream_mux_rr_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(N_CH);

  logic                 out_valid_q;
  logic [DW-1:0]        out_data_q;
  logic [SEL_W-1:0]     out_ch_q;
  logic [SEL_W-1:0]     rr_ptr_q;

  logic                 load_c;
  logic                 rr_hit_c;
  logic [SEL_W-1:0]     rr_ch_c;
  logic [SEL_W-1:0]     rr_idx_c;
  logic                 chosen_c;
  logic [SEL_W-1:0]     ch_c;
  logic                 grant_c;
  logic                 vsel_c;
  logic                 xfer_c;
  logic [DW-1:0]        data_c;
  logic [N_CH-1:0]      in_ready_c;

  // The output slot is free when empty or draining this cycle.
  assign load_c = !out_valid_q || bus.out_ready;

  // Round-robin scan: first valid channel after the last one served.
  always_comb begin
    rr_hit_c = 1'b0;
    rr_ch_c  = '0;
    rr_idx_c = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      rr_idx_c = SEL_W'((32'(rr_ptr_q) + k) % N_CH);
      if (!rr_hit_c && bus.in_valid[rr_idx_c]) begin
        rr_hit_c = 1'b1;
        rr_ch_c  = rr_idx_c;
      end
    end
  end

  // Channel choice; an out-of-range sel chooses nothing.
  always_comb begin
    ch_c     = bus.sel;
    chosen_c = 32'(bus.sel) < N_CH;
    if (bus.mode) begin
      ch_c     = rr_ch_c;
      chosen_c = rr_hit_c;
    end
  end

  assign grant_c = !rst && chosen_c && load_c;

  // Per-channel steering: data/valid of the chosen channel and its ready.
  always_comb begin
    data_c     = '0;
    vsel_c     = 1'b0;
    in_ready_c = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (ch_c == SEL_W'(i)) begin
        data_c        = bus.in_data[i*DW +: DW];
        vsel_c        = bus.in_valid[i];
        in_ready_c[i] = grant_c;
      end
    end
  end

  assign xfer_c = grant_c && vsel_c;

  // Output register and round-robin pointer; a beat held at reset is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= SEL_W'(N_CH - 1);
    end else if (xfer_c) begin
      out_valid_q <= 1'b1;
      out_data_q  <= data_c;
      out_ch_q    <= ch_c;
      rr_ptr_q    <= ch_c;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: two instances (8x1 and 6x8) against a transaction-level model.
module tb_stream_mux_rr;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  stream_mux_rr_if #(.N_CH(8), .DW(1)) ia ();
  stream_mux_rr_if #(.N_CH(6), .DW(8)) ib ();

  stream_mux_rr #(.N_CH(8), .DW(1)) u_a (.clk(clk), .rst(rst), .bus(ia));
  stream_mux_rr #(.N_CH(6), .DW(8)) u_b (.clk(clk), .rst(rst), .bus(ib));

  typedef struct {
    bit         v;
    logic [7:0] d;
    int         ch;
    int         rr;
  } mstate_t;

  mstate_t ma, mb;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input logic v, input logic [7:0] d, input logic [7:0] ch);
    return {15'd0, v, d, ch};
  endfunction

  function automatic mstate_t mreset(input int n);
    mstate_t r;
    r.v = 1'b0; r.d = 8'h00; r.ch = 0; r.rr = n - 1;
    return r;
  endfunction

  // One clock of the mux, described by its transfer rules.
  function automatic mstate_t model_next(input mstate_t s, input int n, input int dw, input bit r,
                                         input bit mode, input int sel, input logic [15:0] iv,
                                         input logic [127:0] id, input bit ordy,
                                         output logic [15:0] rdy);
    mstate_t nx = s;
    int c = -1;
    bit slot_free;
    rdy = '0;
    if (r) return mreset(n);
    if (!mode) begin
      if (sel < n) c = sel;
    end else begin
      for (int k = 1; k <= n; k++) begin
        int j = (s.rr + k) % n;
        if (c < 0 && iv[j]) c = j;
      end
    end
    slot_free = !s.v || ordy;
    if (c >= 0 && slot_free) rdy[c] = 1'b1;
    if (c >= 0 && slot_free && iv[c]) begin
      nx.v  = 1'b1;
      nx.ch = c;
      nx.rr = c;
      nx.d  = 8'((id >> (c * dw)) & ((128'(1) << dw) - 128'(1)));
    end else if (s.v && ordy) begin
      nx.v = 1'b0;
    end
    return nx;
  endfunction

  // Advance one cycle: check readies before the edge, registered outputs after it.
  task automatic step(input string tag);
    logic [15:0] ra, rb;
    mstate_t na, nb;
    @(negedge clk);
    na = model_next(ma, 8, 1, rst, ia.mode, int'(ia.sel), 16'(ia.in_valid),
                    128'(ia.in_data), ia.out_ready, ra);
    nb = model_next(mb, 6, 8, rst, ib.mode, int'(ib.sel), 16'(ib.in_valid),
                    128'(ib.in_data), ib.out_ready, rb);
    check({tag, ":a.in_ready"}, 32'(ia.in_ready), 32'(ra));
    check({tag, ":b.in_ready"}, 32'(ib.in_ready), 32'(rb));
    @(posedge clk);
    ma = na;
    mb = nb;
    #1;
    check({tag, ":a.out"}, pk(ia.out_valid, 8'(ia.out_data), 8'(ia.out_ch)),
          pk(ma.v, ma.d, 8'(ma.ch)));
    check({tag, ":b.out"}, pk(ib.out_valid, ib.out_data, 8'(ib.out_ch)),
          pk(mb.v, mb.d, 8'(mb.ch)));
  endtask

  logic [7:0] lv_data [4];
  logic [2:0] lv_sel  [4];
  logic       lv_exp  [4];
  int         rr_exp  [6];

  initial begin
    lv_data = '{8'b1011_0000, 8'b0011_1001, 8'b0001_1010, 8'b1110_0011};
    lv_sel  = '{3'd5, 3'd3, 3'd6, 3'd2};
    lv_exp  = '{1'b1, 1'b1, 1'b0, 1'b0};
    rr_exp  = '{0, 2, 7, 0, 2, 7};

    rst = 1'b1;
    ia.mode = 1'b0; ia.sel = '0; ia.in_data = '0; ia.in_valid = '0; ia.out_ready = 1'b1;
    ib.mode = 1'b0; ib.sel = '0; ib.in_data = '0; ib.in_valid = '0; ib.out_ready = 1'b1;
    ma = mreset(8);
    mb = mreset(6);
    step("init");
    step("init");
    rst = 1'b0;

    // Legacy 8:1 single-bit vectors in fixed-select mode.
    ia.in_valid = 8'hFF;
    for (int v = 0; v < 4; v++) begin
      ia.in_data = lv_data[v];
      ia.sel     = lv_sel[v];
      step("legacy");
      check("legacy_bit", 32'(ia.out_data), 32'(lv_exp[v]));
      check("legacy_ch", 32'(ia.out_ch), 32'(lv_sel[v]));
    end

    // Selected channel not valid: ready offered, nothing moves, output drains.
    ia.sel = 3'd4;
    ia.in_valid = 8'hEF;
    step("bad_valid");
    check("bad_valid_drop", 32'(ia.out_valid), 32'd0);

    // Out-of-range select on the 6-channel instance.
    ib.sel = 3'd7;
    ib.in_valid = 6'h3F;
    ib.in_data = 48'h1122_3344_5566;
    step("oor");
    check("oor_in_ready", 32'(ib.in_ready), 32'd0);
    check("oor_out_valid", 32'(ib.out_valid), 32'd0);

    // Mode switch resumes round-robin after the last served channel.
    ia.sel = 3'd4;
    ia.in_valid = 8'hFF;
    step("msw");
    check("msw_ch0", 32'(ia.out_ch), 32'd4);
    ia.mode = 1'b1;
    step("msw");
    check("msw_ch1", 32'(ia.out_ch), 32'd5);
    step("msw");
    check("msw_ch2", 32'(ia.out_ch), 32'd6);

    // Backpressure holds the beat; release loads the next beat with no bubble.
    ib.sel = 3'd2;
    ib.in_data = 48'h1122_33A5_4455;
    ib.out_ready = 1'b1;
    step("bp");
    check("bp_load", pk(ib.out_valid, ib.out_data, 8'(ib.out_ch)), pk(1'b1, 8'hA5, 8'd2));
    ib.out_ready = 1'b0;
    ib.in_data = 48'h1122_333C_4455;
    for (int i = 0; i < 3; i++) begin
      step("bp_hold");
      check("bp_hold_out", pk(ib.out_valid, ib.out_data, 8'(ib.out_ch)), pk(1'b1, 8'hA5, 8'd2));
      check("bp_hold_rdy", 32'(ib.in_ready), 32'd0);
    end
    ib.out_ready = 1'b1;
    step("bp_rel");
    check("bp_next", pk(ib.out_valid, ib.out_data, 8'(ib.out_ch)), pk(1'b1, 8'h3C, 8'd2));

    // Reset mid-stream with a held beat.
    ia.mode = 1'b1;
    ia.in_valid = 8'hFF;
    ia.out_ready = 1'b0;
    step("pre_rst");
    check("pre_rst_valid", 32'(ia.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_a_out", pk(ia.out_valid, 8'(ia.out_data), 8'(ia.out_ch)), 32'd0);
    check("rst_b_out", pk(ib.out_valid, ib.out_data, 8'(ib.out_ch)), 32'd0);
    check("rst_a_rdy", 32'(ia.in_ready), 32'd0);
    ma = mreset(8);
    mb = mreset(6);
    step("rst");
    step("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Round-robin over channels 0, 2, 7 starting from reset pointer.
    ia.in_valid = 8'b1000_0101;
    ia.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step("rr");
      check("rr_ch", pk(ia.out_valid, 8'd0, 8'(ia.out_ch)), pk(1'b1, 8'd0, 8'(rr_exp[i])));
    end

    // Randomized traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      ia.mode      = 1'($urandom);
      ia.sel       = 3'($urandom);
      ia.in_valid  = 8'($urandom);
      ia.in_data   = 8'($urandom);
      ia.out_ready = ($urandom_range(0, 3) != 0);
      ib.mode      = 1'($urandom);
      ib.sel       = 3'($urandom);
      ib.in_valid  = 6'($urandom);
      ib.in_data   = 48'({$urandom, $urandom});
      ib.out_ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
